// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multicycle controller: state encoding,
// instruction classes, opcode match patterns, ALU/sign-extend selects.
// Pure declarations; no latency or backpressure of its own.
package legv8_ctrl_pkg;

   // FSM state encoding; codes 6 and 7 are unused and recover to FETCH.
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   // Instruction classes; CLS_NONE marks an unrecognised opcode.
   typedef enum logic [3:0] {
      CLS_NONE   = 4'd0,
      CLS_AND    = 4'd1,
      CLS_ORR    = 4'd2,
      CLS_ADDREG = 4'd3,
      CLS_SUBREG = 4'd4,
      CLS_ADDIMM = 4'd5,
      CLS_SUBIMM = 4'd6,
      CLS_MOVZ   = 4'd7,
      CLS_B      = 4'd8,
      CLS_CBZ    = 4'd9,
      CLS_LDUR   = 4'd10,
      CLS_STUR   = 4'd11
   } class_e;

   // One opcode pattern: bits under mask must equal value.
   typedef struct packed {
      logic [10:0] mask;
      logic [10:0] value;
      class_e      cls;
   } opc_pat_t;

   localparam int NUM_PATS = 11;

   // Listed in priority order: the lowest index that matches wins.
   localparam opc_pat_t OPC_PATS [NUM_PATS] = '{
      '{mask: 11'b01111111000, value: 11'b00001010000, cls: CLS_AND   },
      '{mask: 11'b01111111000, value: 11'b00101010000, cls: CLS_ORR   },
      '{mask: 11'b01011111000, value: 11'b00001011000, cls: CLS_ADDREG},
      '{mask: 11'b01011111000, value: 11'b01001011000, cls: CLS_SUBREG},
      '{mask: 11'b01011111000, value: 11'b00010001000, cls: CLS_ADDIMM},
      '{mask: 11'b01011111000, value: 11'b01010001000, cls: CLS_SUBIMM},
      '{mask: 11'b11111111100, value: 11'b11010010100, cls: CLS_MOVZ  },
      '{mask: 11'b01111100000, value: 11'b00010100000, cls: CLS_B     },
      '{mask: 11'b01111110000, value: 11'b00110100000, cls: CLS_CBZ   },
      '{mask: 11'b00111111111, value: 11'b00111000010, cls: CLS_LDUR  },
      '{mask: 11'b00111111111, value: 11'b00111000000, cls: CLS_STUR  }
   };

   // ALU operation selects.
   localparam logic [3:0] ALUOP_AND   = 4'b0000;
   localparam logic [3:0] ALUOP_ORR   = 4'b0001;
   localparam logic [3:0] ALUOP_ADD   = 4'b0010;
   localparam logic [3:0] ALUOP_SUB   = 4'b0110;
   localparam logic [3:0] ALUOP_PASSB = 4'b0111;

   // Immediate sign-extend selects.
   localparam logic [2:0] SIGNOP_IMM  = 3'b000;
   localparam logic [2:0] SIGNOP_BR   = 3'b001;
   localparam logic [2:0] SIGNOP_DT   = 3'b010;
   localparam logic [2:0] SIGNOP_CB   = 3'b011;
   localparam logic [2:0] SIGNOP_MOVZ = 3'b100;

   // Control outputs bundled so reset gating is a single mux.
   typedef struct packed {
      logic       pcwrite;
      logic       irwrite;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic       mem2reg;
      logic       alusrc;
      logic       reg2loc;
      logic       move;
      logic       pcsrc;
      logic       instr_done;
      logic       illegal;
      logic [3:0] aluop;
      logic [2:0] signop;
   } ctrl_t;

   function automatic logic [3:0] class_aluop(input class_e c);
      case (c)
         CLS_ADDREG, CLS_ADDIMM,
         CLS_LDUR, CLS_STUR:     return ALUOP_ADD;
         CLS_SUBREG, CLS_SUBIMM: return ALUOP_SUB;
         CLS_AND:                return ALUOP_AND;
         CLS_ORR:                return ALUOP_ORR;
         CLS_CBZ:                return ALUOP_PASSB;
         default:                return ALUOP_AND;
      endcase
   endfunction

   function automatic logic [2:0] class_signop(input class_e c);
      case (c)
         CLS_ADDIMM, CLS_SUBIMM: return SIGNOP_IMM;
         CLS_B:                  return SIGNOP_BR;
         CLS_LDUR, CLS_STUR:     return SIGNOP_DT;
         CLS_CBZ:                return SIGNOP_CB;
         CLS_MOVZ:               return SIGNOP_MOVZ;
         default:                return 3'b000;
      endcase
   endfunction

   function automatic logic class_alusrc(input class_e c);
      return (c == CLS_ADDIMM) || (c == CLS_SUBIMM) ||
             (c == CLS_LDUR)   || (c == CLS_STUR);
   endfunction

endpackage

// File: rtl/multicycle_control_opclass_decode.sv
// Opcode classifier: maps instruction bits [31:21] to an instruction class.
// Purely combinational, zero latency; no flow control.
// Ports: opcode (11b) in, op_class out (CLS_NONE when nothing matches).
module opclass_decode
   import legv8_ctrl_pkg::*;
(
   input  logic [10:0] opcode,
   output class_e      op_class
);

   // Walk the table from the back so the earliest matching entry is the
   // last one written and therefore wins.
   always_comb begin
      op_class = CLS_NONE;
      for (int i = NUM_PATS - 1; i >= 0; i--) begin
         if ((opcode & OPC_PATS[i].mask) == OPC_PATS[i].value) begin
            op_class = OPC_PATS[i].cls;
         end
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB plus sticky TRAP.
// 3-5 cycles per instruction with zero wait states; each mem_ready=0 cycle
// in FETCH or MEM stalls one cycle. Ports: CLK, resetl, opcode, zero,
// mem_ready in; datapath strobes/selects, instr_done, illegal, state out.
module multicycle_control
   import legv8_ctrl_pkg::*;
(
   input  logic        CLK,
   input  logic        resetl,
   input  logic [10:0] opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pcwrite,
   output logic        irwrite,
   output logic        iord,
   output logic        memread,
   output logic        memwrite,
   output logic        regwrite,
   output logic        mem2reg,
   output logic        alusrc,
   output logic        reg2loc,
   output logic        move,
   output logic        pcsrc,
   output logic        instr_done,
   output logic        illegal,
   output logic [3:0]  aluop,
   output logic [2:0]  signop,
   output logic [2:0]  state
);

   state_e state_q, state_d;
   class_e cls_q, cls_d;
   class_e dec_cls;
   ctrl_t  ctrl_raw;
   ctrl_t  ctrl_out;

   opclass_decode u_decode (
      .opcode   (opcode),
      .op_class (dec_cls)
   );

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q <= ST_FETCH;
         cls_q   <= CLS_NONE;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cls_d    = cls_q;
      ctrl_raw = '0;

      case (state_q)
         ST_FETCH: begin
            ctrl_raw.memread = 1'b1;
            if (mem_ready) begin
               ctrl_raw.irwrite = 1'b1;
               state_d          = ST_DECODE;
            end
         end

         ST_DECODE: begin
            // The IR now holds the new instruction; capture its class so
            // later states do not depend on the opcode bus.
            ctrl_raw.reg2loc = (dec_cls == CLS_STUR) || (dec_cls == CLS_CBZ);
            cls_d            = dec_cls;
            state_d          = (dec_cls == CLS_NONE) ? ST_TRAP : ST_EXEC;
         end

         ST_EXEC: begin
            ctrl_raw.aluop  = class_aluop(cls_q);
            ctrl_raw.signop = class_signop(cls_q);
            ctrl_raw.alusrc = class_alusrc(cls_q);
            case (cls_q)
               CLS_B: begin
                  ctrl_raw.pcwrite    = 1'b1;
                  ctrl_raw.pcsrc      = 1'b1;
                  ctrl_raw.instr_done = 1'b1;
                  state_d             = ST_FETCH;
               end
               CLS_CBZ: begin
                  // PC is always written; zero picks branch target vs PC+4.
                  ctrl_raw.pcwrite    = 1'b1;
                  ctrl_raw.pcsrc      = zero;
                  ctrl_raw.instr_done = 1'b1;
                  state_d             = ST_FETCH;
               end
               CLS_LDUR, CLS_STUR: state_d = ST_MEM;
               CLS_NONE:           state_d = ST_TRAP;
               default:            state_d = ST_WB;
            endcase
         end

         ST_MEM: begin
            ctrl_raw.iord     = 1'b1;
            ctrl_raw.memread  = (cls_q == CLS_LDUR);
            ctrl_raw.memwrite = (cls_q == CLS_STUR);
            if (mem_ready) begin
               if (cls_q == CLS_STUR) begin
                  ctrl_raw.pcwrite    = 1'b1;
                  ctrl_raw.instr_done = 1'b1;
                  state_d             = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
         end

         ST_WB: begin
            ctrl_raw.regwrite   = 1'b1;
            ctrl_raw.pcwrite    = 1'b1;
            ctrl_raw.instr_done = 1'b1;
            ctrl_raw.mem2reg    = (cls_q == CLS_LDUR);
            ctrl_raw.move       = (cls_q == CLS_MOVZ);
            state_d             = ST_FETCH;
         end

         ST_TRAP: begin
            ctrl_raw.illegal = 1'b1;
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // While reset is held the FETCH state would otherwise show memread=1;
   // gate everything so outputs drop the instant resetl falls.
   assign ctrl_out = resetl ? ctrl_raw : '0;

   assign pcwrite    = ctrl_out.pcwrite;
   assign irwrite    = ctrl_out.irwrite;
   assign iord       = ctrl_out.iord;
   assign memread    = ctrl_out.memread;
   assign memwrite   = ctrl_out.memwrite;
   assign regwrite   = ctrl_out.regwrite;
   assign mem2reg    = ctrl_out.mem2reg;
   assign alusrc     = ctrl_out.alusrc;
   assign reg2loc    = ctrl_out.reg2loc;
   assign move       = ctrl_out.move;
   assign pcsrc      = ctrl_out.pcsrc;
   assign instr_done = ctrl_out.instr_done;
   assign illegal    = ctrl_out.illegal;
   assign aluop      = ctrl_out.aluop;
   assign signop     = ctrl_out.signop;
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   logic        CLK = 1'b0;
   logic        resetl = 1'b0;
   logic [10:0] opcode = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pcwrite, irwrite, iord, memread, memwrite, regwrite, mem2reg;
   logic        alusrc, reg2loc, move, pcsrc, instr_done, illegal;
   logic [3:0]  aluop;
   logic [2:0]  signop;
   logic [2:0]  state;

   multicycle_control dut (
      .CLK(CLK), .resetl(resetl), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pcwrite(pcwrite), .irwrite(irwrite),
      .iord(iord), .memread(memread), .memwrite(memwrite),
      .regwrite(regwrite), .mem2reg(mem2reg), .alusrc(alusrc),
      .reg2loc(reg2loc), .move(move), .pcsrc(pcsrc),
      .instr_done(instr_done), .illegal(illegal), .aluop(aluop),
      .signop(signop), .state(state)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [2:0] st;
      logic pcwrite, irwrite, iord, memread, memwrite, regwrite, mem2reg;
      logic alusrc, reg2loc, move, pcsrc, instr_done, illegal;
      logic [3:0] aluop;
      logic [2:0] signop;
   } obs_t;

   typedef struct {
      obs_t  e;
      logic  mr;
      logic  z;
      string tag;
   } step_t;

   step_t q[$];
   int check_cnt = 0;
   int pass_cnt  = 0;

   // Class index: 0 AND 1 ORR 2 ADDREG 3 SUBREG 4 ADDIMM 5 SUBIMM
   //              6 MOVZ 7 B 8 CBZ 9 LDUR 10 STUR
   string pats [11] = '{"x0001010xxx", "x0101010xxx", "x0x01011xxx",
                        "x1x01011xxx", "x0x10001xxx", "x1x10001xxx",
                        "110100101xx", "x00101xxxxx", "x011010xxxx",
                        "xx111000010", "xx111000000"};

   function automatic int classify(input logic [10:0] op);
      for (int k = 0; k < 11; k++) begin
         bit ok = 1'b1;
         for (int i = 0; i < 11; i++) begin
            byte c = pats[k][i];
            if (c == "1" && !op[10-i]) ok = 1'b0;
            if (c == "0" &&  op[10-i]) ok = 1'b0;
         end
         if (ok) return k;
      end
      return -1;
   endfunction

   function automatic logic [10:0] sample_op(input int k);
      logic [10:0] op = 11'($urandom);
      for (int i = 0; i < 11; i++) begin
         byte c = pats[k][i];
         if (c == "1") op[10-i] = 1'b1;
         if (c == "0") op[10-i] = 1'b0;
      end
      return op;
   endfunction

   function automatic obs_t get_obs();
      obs_t o;
      o.st = state; o.pcwrite = pcwrite; o.irwrite = irwrite; o.iord = iord;
      o.memread = memread; o.memwrite = memwrite; o.regwrite = regwrite;
      o.mem2reg = mem2reg; o.alusrc = alusrc; o.reg2loc = reg2loc;
      o.move = move; o.pcsrc = pcsrc; o.instr_done = instr_done;
      o.illegal = illegal; o.aluop = aluop; o.signop = signop;
      return o;
   endfunction

   function automatic obs_t mk(input logic [2:0] st);
      obs_t r = '0;
      r.st = st;
      return r;
   endfunction

   task automatic check(input string tag, input obs_t o, input obs_t e);
      check_cnt++;
      assert (o === e) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, o, e);
   endtask

   task automatic add(input obs_t e, input logic mr, input logic z, input string tag);
      step_t s;
      s.e = e; s.mr = mr; s.z = z; s.tag = tag;
      q.push_back(s);
   endtask

   // Expected per-cycle trace of one instruction, derived from the
   // class rules. dc=1 randomises inputs that must be ignored.
   task automatic build(input logic [10:0] op, input int fw, input int mw,
                        input logic z, input bit dc, input int trap_n, input string nm);
      int   k = classify(op);
      obs_t e;
      for (int w = 0; w < fw; w++) begin
         e = mk(3'd0); e.memread = 1'b1;
         add(e, 1'b0, 1'($urandom), $sformatf("%s_fetchwait%0d", nm, w));
      end
      e = mk(3'd0); e.memread = 1'b1; e.irwrite = 1'b1;
      add(e, 1'b1, 1'($urandom), {nm, "_fetch"});
      e = mk(3'd1); e.reg2loc = (k == 8 || k == 10);
      add(e, dc ? 1'($urandom) : 1'b1, 1'($urandom), {nm, "_decode"});
      if (k < 0) begin
         for (int t = 0; t < trap_n; t++) begin
            e = mk(3'd5); e.illegal = 1'b1;
            add(e, dc ? 1'($urandom) : 1'b1, 1'($urandom), $sformatf("%s_trap%0d", nm, t));
         end
         return;
      end
      e = mk(3'd2);
      case (k)
         2, 4, 9, 10: e.aluop = 4'b0010;
         3, 5:        e.aluop = 4'b0110;
         1:           e.aluop = 4'b0001;
         8:           e.aluop = 4'b0111;
         default:     e.aluop = 4'b0000;
      endcase
      e.alusrc = (k == 4 || k == 5 || k == 9 || k == 10);
      case (k)
         7:       e.signop = 3'b001;
         9, 10:   e.signop = 3'b010;
         8:       e.signop = 3'b011;
         6:       e.signop = 3'b100;
         default: e.signop = 3'b000;
      endcase
      if (k == 7 || k == 8) begin
         e.pcwrite = 1'b1; e.instr_done = 1'b1;
         e.pcsrc = (k == 7) ? 1'b1 : z;
      end
      add(e, dc ? 1'($urandom) : 1'b1, z, {nm, "_exec"});
      if (k == 7 || k == 8) return;
      if (k == 9 || k == 10) begin
         for (int w = 0; w <= mw; w++) begin
            e = mk(3'd3); e.iord = 1'b1;
            e.memread = (k == 9); e.memwrite = (k == 10);
            if (w == mw && k == 10) begin
               e.pcwrite = 1'b1; e.instr_done = 1'b1;
            end
            add(e, (w == mw), 1'($urandom), $sformatf("%s_mem%0d", nm, w));
         end
         if (k == 10) return;
      end
      e = mk(3'd4); e.regwrite = 1'b1; e.pcwrite = 1'b1; e.instr_done = 1'b1;
      e.mem2reg = (k == 9); e.move = (k == 6);
      add(e, dc ? 1'($urandom) : 1'b1, 1'($urandom), {nm, "_wb"});
   endtask

   task automatic run();
      while (q.size() > 0) begin
         step_t s = q.pop_front();
         @(negedge CLK);
         mem_ready = s.mr;
         zero      = s.z;
         #1;
         check(s.tag, get_obs(), s.e);
      end
   endtask

   // Drop reset mid-cycle, confirm outputs clear without a clock edge,
   // hold across an edge, then release with the fetch stalled.
   task automatic reset_pulse(input string tag);
      @(negedge CLK);
      #2 resetl = 1'b0;
      #1 check({tag, "_async"}, get_obs(), obs_t'(0));
      @(posedge CLK);
      #1 check({tag, "_held"}, get_obs(), obs_t'(0));
      mem_ready = 1'b0;
      @(negedge CLK);
      #1 resetl = 1'b1;
   endtask

   initial begin
      logic [10:0] op;
      #1 check("por", get_obs(), obs_t'(0));
      @(negedge CLK);
      #1 resetl = 1'b1;

      opcode = 11'b10001011000;                        // ADD (register)
      build(opcode, 0, 0, 1'b0, 1'b0, 0, "addreg"); run();

      opcode = 11'b11111000010;                        // LDUR, 2 mem waits
      build(opcode, 0, 2, 1'b0, 1'b0, 0, "ldur"); run();

      opcode = 11'b10110100000;                        // CBZ taken
      build(opcode, 0, 0, 1'b1, 1'b0, 0, "cbz_z1"); run();
      build(opcode, 0, 0, 1'b0, 1'b0, 0, "cbz_z0"); run();

      opcode = 11'b11010010100;                        // MOVZ
      build(opcode, 1, 0, 1'b0, 1'b0, 0, "movz"); run();

      opcode = 11'b00000000000;                        // illegal
      build(opcode, 0, 0, 1'b0, 1'b0, 20, "illegal"); run();
      reset_pulse("trap_rst");

      opcode = 11'b11111000000;                        // STUR cut by reset
      build(opcode, 0, 2, 1'b0, 1'b0, 0, "stur_cut");
      void'(q.pop_back());
      run();
      reset_pulse("stur_rst");

      opcode = 11'b10010001000;                        // ADDIMM after reset
      build(opcode, 2, 0, 1'b0, 1'b0, 0, "post_rst"); run();

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 7) == 0) op = 11'($urandom);
         else                           op = sample_op(int'($urandom_range(0, 10)));
         opcode = op;
         build(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               1'($urandom), 1'b1, int'($urandom_range(2, 5)), $sformatf("rnd%0d", n));
         run();
         if (classify(op) < 0) reset_pulse($sformatf("rnd%0d_rst", n));
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port CLK, input, 1, the single rising-edge clock.
REQ-002 SHALL have port resetl, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port opcode, input, 11, instruction bits [31:21] from the instruction register.
REQ-004 SHALL have port zero, input, 1, ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1, memory transfer-complete handshake.
REQ-006 SHALL have outputs pcwrite, irwrite, iord, memread, memwrite, regwrite, mem2reg, alusrc, reg2loc, move, pcsrc, instr_done, illegal, each 1 bit.
REQ-007 SHALL have outputs aluop (4 bits), signop (3 bits) and state (3 bits, current FSM state).

Function
REQ-008 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-009 FETCH SHALL assert memread=1 and iord=0; SHALL hold while mem_ready=0; on mem_ready=1 SHALL assert irwrite=1 that cycle and go to DECODE.
REQ-010 DECODE SHALL classify opcode and latch the class for the rest of the instruction.
REQ-010a DECODE SHALL drive reg2loc=1 for STUR and CBZ, otherwise 0.
REQ-010b DECODE SHALL go to TRAP for unmatched opcodes, otherwise to EXEC.
REQ-011 Opcode classes (x = don't care):
- ANDREG x0001010xxx
- ORRREG x0101010xxx
- ADDREG x0x01011xxx
- SUBREG x1x01011xxx
- ADDIMM x0x10001xxx
- SUBIMM x1x10001xxx
- MOVZ 110100101xx
- B x00101xxxxx
- CBZ x011010xxxx
- LDUR xx111000010
- STUR xx111000000
- First match in this order SHALL win.
REQ-012 EXEC aluop SHALL be:
- 0010 for ADD, LDUR and STUR
- 0110 for SUB
- 0000 for AND
- 0001 for ORR
- 0111 (pass B) for CBZ
- 0000 otherwise
REQ-013 EXEC alusrc SHALL be 1 for IMM, LDUR and STUR.
REQ-014 EXEC signop SHALL be:
- 000 for IMM
- 001 for B
- 010 for LDUR and STUR
- 011 for CBZ
- 100 for MOVZ
REQ-015 B in EXEC SHALL assert pcwrite=1, pcsrc=1 and instr_done=1, then go to FETCH.
REQ-016 CBZ in EXEC SHALL assert pcwrite=1, pcsrc=zero and instr_done=1, then go to FETCH.
REQ-017 LDUR and STUR SHALL go from EXEC to MEM; all other classes SHALL go from EXEC to WB.
REQ-018 MEM SHALL assert iord=1, with memread=1 for LDUR or memwrite=1 for STUR, and SHALL hold while mem_ready=0.
REQ-019 On mem_ready=1 in MEM, LDUR SHALL go to WB.
REQ-019a On mem_ready=1 in MEM, STUR SHALL assert pcwrite=1, pcsrc=0 and instr_done=1, then go to FETCH.
REQ-020 WB SHALL assert regwrite=1, pcwrite=1, pcsrc=0 and instr_done=1, then go to FETCH.
REQ-020a WB SHALL drive mem2reg=1 only for LDUR and move=1 only for MOVZ.
REQ-021 TRAP SHALL assert illegal=1, drive all write strobes to 0, and remain in TRAP until reset.
REQ-022 Every output not named as asserted in a state SHALL be driven 0; no output SHALL ever be X.
REQ-023 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-023a Outputs SHALL be Moore-style except irwrite, pcwrite, pcsrc and instr_done, which may depend on mem_ready or zero in the same cycle.
REQ-024 With zero wait states, instruction latency SHALL be:
- B and CBZ: 3 cycles
- R-type, IMM, MOVZ and STUR: 4 cycles
- LDUR: 5 cycles
REQ-025 Each wait cycle SHALL add exactly one cycle to this latency.

Reset
REQ-026 resetl=0 SHALL immediately force state=FETCH, clear the latched class, and drive every output to 0.
REQ-026a This SHALL hold even mid-instruction or mid-wait.
REQ-027 After resetl rises, the first rising edge with mem_ready=1 SHALL complete the fetch.

Structure
REQ-028 Package legv8_ctrl_pkg SHALL hold:
- the state encoding
- the class enumeration
- the opcode patterns
- the aluop constants (ADD, SUB, AND, ORR, PASSB)
- the signop constants
REQ-029 Opcode classification SHALL be a combinational submodule opclass_decode (opcode in, class out).
REQ-029a The FSM and output logic SHALL reside in multicycle_control.

Verification
REQ-030 ADDREG, mem_ready held 1 -> states 0,1,2,4; regwrite=1 and instr_done=1 only in cycle 4; aluop=0010 in EXEC.
REQ-031 LDUR with mem_ready low for 2 MEM cycles -> state 3 for 3 cycles with memread=1, iord=1; then WB with mem2reg=1, regwrite=1; 7 cycles total.
REQ-032 CBZ with zero=1, then zero=0 -> EXEC pcsrc=1, then pcsrc=0; pcwrite=1 and regwrite=0 both times; 3 cycles each.
REQ-033 opcode 11'b00000000000 -> TRAP in cycle 3; illegal=1 is sticky for 20 cycles; resetl low returns to FETCH.
REQ-034 resetl pulsed low during STUR MEM wait -> memwrite drops asynchronously; state=0 before the next edge; no instr_done.
REQ-035 MOVZ -> EXEC signop=100; WB move=1, regwrite=1, mem2reg=0.
